// File: rtl/nes_oam_dma_if.sv
// CPU-side and DMA-side bus signals of the sprite OAM DMA engine.
// The engine drives through master; the system bus and memory attach to slave.
interface nes_oam_dma_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_rw_n;
    logic [7:0]  bus_din;
    logic        cpu_rdy;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic [7:0]  dma_dout;
    logic        dma_rw_n;
    logic        dma_done;

    modport master (
        input  cpu_addr, cpu_dout, cpu_rw_n, bus_din,
        output cpu_rdy, dma_active, dma_addr, dma_dout, dma_rw_n, dma_done
    );

    modport slave (
        output cpu_addr, cpu_dout, cpu_rw_n, bus_din,
        input  cpu_rdy, dma_active, dma_addr, dma_dout, dma_rw_n, dma_done
    );
endinterface

// File: rtl/nes_oam_dma.sv
// Sprite OAM DMA: a CPU write of page N to the trigger register halts the CPU
// and copies N*256..N*256+255 to the OAM data port, one GET/PUT pair per byte.
module nes_oam_dma #(
    parameter logic [15:0] TRIG_ADDR = 16'h4014,
    parameter logic [15:0] OAM_ADDR  = 16'h2004
) (
    input  logic          clk,
    input  logic          rst_n,
    nes_oam_dma_if.master bus
);
    localparam int unsigned NUM_BYTES = 256;
    localparam logic [7:0]  LAST_IDX  = 8'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    state_t      state_q, state_d;
    logic        parity_q;
    logic [7:0]  page_q, page_d;
    logic [7:0]  index_q, index_d;
    logic [7:0]  latch_q, latch_d;
    logic        rdy_q, rdy_d;
    logic        active_q, active_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  dout_q, dout_d;
    logic        rw_n_q, rw_n_d;
    logic        done_q, done_d;

    // State, datapath and registered bus outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            parity_q <= 1'b0;
            page_q   <= 8'h00;
            index_q  <= 8'h00;
            latch_q  <= 8'h00;
            rdy_q    <= 1'b1;
            active_q <= 1'b0;
            addr_q   <= 16'h0000;
            dout_q   <= 8'h00;
            rw_n_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            parity_q <= ~parity_q;
            page_q   <= page_d;
            index_q  <= index_d;
            latch_q  <= latch_d;
            rdy_q    <= rdy_d;
            active_q <= active_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
            rw_n_q   <= rw_n_d;
            done_q   <= done_d;
        end
    end

    // Next state, then outputs decoded from the state being entered
    always_comb begin
        state_d  = state_q;
        page_d   = page_q;
        index_d  = index_q;
        latch_d  = latch_q;
        rdy_d    = 1'b0;
        active_d = 1'b0;
        addr_d   = 16'h0000;
        dout_d   = 8'h00;
        rw_n_d   = 1'b1;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!bus.cpu_rw_n && (bus.cpu_addr == TRIG_ADDR)) begin
                    state_d = S_HALT;
                    page_d  = bus.cpu_dout;
                    index_d = 8'h00;
                end
            end
            // parity flips at this edge, so parity_q=1 here means the next cycle is GET
            S_HALT:  state_d = parity_q ? S_READ : S_ALIGN;
            S_ALIGN: state_d = S_READ;
            S_READ: begin
                latch_d = bus.bus_din;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                index_d = index_q + 8'd1;
                if (index_q == LAST_IDX) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_READ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_IDLE: rdy_d = 1'b1;
            S_READ: begin
                active_d = 1'b1;
                addr_d   = {page_d, index_d};
            end
            S_WRITE: begin
                active_d = 1'b1;
                rw_n_d   = 1'b0;
                addr_d   = OAM_ADDR;
                dout_d   = latch_d;
            end
            default: ;
        endcase
    end

    assign bus.cpu_rdy    = rdy_q;
    assign bus.dma_active = active_q;
    assign bus.dma_addr   = addr_q;
    assign bus.dma_dout   = dout_q;
    assign bus.dma_rw_n   = rw_n_q;
    assign bus.dma_done   = done_q;
endmodule
